// File: rtl/alu_btn_sequencer.sv
// alu_btn_sequencer
//   Operand/opcode sequencer for the board-level ALU demo. It debounces three
//   raw push-buttons and then walks through loading operand A, operand B and
//   the opcode from the slide switches. It drives the external ALU's inputs
//   and registers the ALU result onto the LEDs together with a valid flag.
//
// Ports
//   i_clk         single rising-edge clock
//   i_reset       synchronous, active-high reset
//   i_sw          slide switches, sampled directly when a press is acted on
//   i_btn         raw buttons: [0] load A, [1] load B, [2] load opcode
//   i_alu_result  combinational result from the external ALU
//   o_alu_data_A  registered operand A
//   o_alu_data_B  registered operand B
//   o_alu_op      registered opcode
//   o_led         registered result (low bits, zero-extended if narrower)
//   o_valid       o_led holds the result for the current A/B/op
//   o_state       current FSM state encoding
module alu_btn_sequencer #(
    parameter int NB_SW           = 8,
    parameter int NB_DATA         = 8,
    parameter int NB_OP           = 6,
    parameter int NB_LEDS         = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_SW-1:0]   i_sw,
    input  logic [2:0]         i_btn,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic [NB_DATA-1:0] o_alu_data_A,
    output logic [NB_DATA-1:0] o_alu_data_B,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic [NB_LEDS-1:0] o_led,
    output logic               o_valid,
    output logic [2:0]         o_state
);

    // Counter only has to hold 0..DEBOUNCE_CYCLES-1: the level toggles on the
    // sample that would have made it reach DEBOUNCE_CYCLES.
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int NB_EXT = (NB_LEDS > NB_DATA) ? NB_LEDS : NB_DATA;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    logic [2:0]       sync_1;
    logic [2:0]       sync_2;
    logic [2:0]       level;
    logic [2:0]       level_q;
    logic [2:0]       press;
    logic [CNT_W-1:0] cnt [3];

    state_t state;
    state_t state_next;
    logic   load_a;
    logic   load_b;
    logic   load_op;
    logic   capture;
    logic   clear_valid;

    logic [NB_EXT-1:0] result_ext;

    // Button front end: 2-FF synchroniser, debounce counter, registered
    // rising-edge pulse on the debounced level.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_1  <= '0;
            sync_2  <= '0;
            level   <= '0;
            level_q <= '0;
            press   <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_1  <= i_btn;
            sync_2  <= sync_1;
            level_q <= level;
            press   <= level & ~level_q;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync_2[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= ~level[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= LOAD_A;
        end else begin
            state <= state_next;
        end
    end

    // Priority press[0] > press[1] > press[2]; only the highest legal press acts.
    always_comb begin
        state_next  = state;
        load_a      = 1'b0;
        load_b      = 1'b0;
        load_op     = 1'b0;
        capture     = 1'b0;
        clear_valid = 1'b0;
        case (state)
            LOAD_A: begin
                if (press[0]) begin
                    load_a     = 1'b1;
                    state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press[1]) begin
                    load_b     = 1'b1;
                    state_next = LOAD_OP;
                end
            end
            LOAD_OP: begin
                if (press[2]) begin
                    load_op    = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = SHOW;
            end
            SHOW: begin
                if (press[0]) begin
                    load_a      = 1'b1;
                    clear_valid = 1'b1;
                    state_next  = LOAD_B;
                end else if (press[1]) begin
                    load_b      = 1'b1;
                    clear_valid = 1'b1;
                    state_next  = EXEC;
                end else if (press[2]) begin
                    load_op     = 1'b1;
                    clear_valid = 1'b1;
                    state_next  = EXEC;
                end
            end
            default: begin
                clear_valid = 1'b1;
                state_next  = LOAD_A;
            end
        endcase
    end

    assign result_ext = NB_EXT'(i_alu_result);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_alu_data_A <= '0;
            o_alu_data_B <= '0;
            o_alu_op     <= '0;
            o_led        <= '0;
            o_valid      <= 1'b0;
        end else begin
            if (load_a) begin
                o_alu_data_A <= i_sw[NB_DATA-1:0];
            end
            if (load_b) begin
                o_alu_data_B <= i_sw[NB_DATA-1:0];
            end
            if (load_op) begin
                o_alu_op <= i_sw[NB_OP-1:0];
            end
            if (capture) begin
                o_led   <= result_ext[NB_LEDS-1:0];
                o_valid <= 1'b1;
            end else if (clear_valid) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_alu_btn_sequencer.sv
// Self-checking bench for alu_btn_sequencer with a stub ALU
// (op 20h: A+B, op 22h: A-B, otherwise 0).
module tb_alu_btn_sequencer;

    logic       clk;
    logic       reset;
    logic [7:0] sw;
    logic [2:0] btn;
    logic [7:0] alu_result;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] led;
    logic       valid;
    logic [2:0] state;

    int unsigned total;
    int unsigned bad;

    typedef struct {
        logic [7:0] sw;
        logic [2:0] btn;
        logic [2:0] st;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic       v;
        logic [7:0] led;
    } vec_t;

    vec_t vecs [14];
    vec_t exp_q [$];

    alu_btn_sequencer #(
        .NB_SW(8),
        .NB_DATA(8),
        .NB_OP(6),
        .NB_LEDS(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_sw(sw),
        .i_btn(btn),
        .i_alu_result(alu_result),
        .o_alu_data_A(alu_a),
        .o_alu_data_B(alu_b),
        .o_alu_op(alu_op),
        .o_led(led),
        .o_valid(valid),
        .o_state(state)
    );

    always_comb begin
        alu_result = 8'h00;
        if (alu_op == 6'h20) begin
            alu_result = alu_a + alu_b;
        end else if (alu_op == 6'h22) begin
            alu_result = alu_a - alu_b;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press_btn(input logic [7:0] s, input logic [2:0] mask);
        sw  = s;
        btn = mask;
        step(10);
        btn = 3'b000;
        step(12);
    endtask

    task automatic check_all(input string tag, input vec_t e);
        check({tag, ".state"}, 32'(state), 32'(e.st));
        check({tag, ".a"}, 32'(alu_a), 32'(e.a));
        check({tag, ".b"}, 32'(alu_b), 32'(e.b));
        check({tag, ".op"}, 32'(alu_op), 32'(e.op));
        check({tag, ".valid"}, 32'(valid), 32'(e.v));
        check({tag, ".led"}, 32'(led), 32'(e.led));
    endtask

    initial begin
        vec_t e;
        total = 0;
        bad   = 0;

        //            sw     btn     st    a      b      op     v     led
        vecs[0]  = '{8'h00, 3'b010, 3'd0, 8'h00, 8'h00, 6'h00, 1'b0, 8'h00};
        vecs[1]  = '{8'h00, 3'b100, 3'd0, 8'h00, 8'h00, 6'h00, 1'b0, 8'h00};
        vecs[2]  = '{8'h05, 3'b001, 3'd1, 8'h05, 8'h00, 6'h00, 1'b0, 8'h00};
        vecs[3]  = '{8'h03, 3'b010, 3'd2, 8'h05, 8'h03, 6'h00, 1'b0, 8'h00};
        vecs[4]  = '{8'h20, 3'b100, 3'd4, 8'h05, 8'h03, 6'h20, 1'b1, 8'h08};
        vecs[5]  = '{8'h22, 3'b100, 3'd4, 8'h05, 8'h03, 6'h22, 1'b1, 8'h02};
        vecs[6]  = '{8'h07, 3'b001, 3'd1, 8'h07, 8'h03, 6'h22, 1'b0, 8'h02};
        vecs[7]  = '{8'h04, 3'b010, 3'd2, 8'h07, 8'h04, 6'h22, 1'b0, 8'h02};
        vecs[8]  = '{8'h20, 3'b100, 3'd4, 8'h07, 8'h04, 6'h20, 1'b1, 8'h0B};
        vecs[9]  = '{8'h10, 3'b011, 3'd1, 8'h10, 8'h04, 6'h20, 1'b0, 8'h0B};
        vecs[10] = '{8'h09, 3'b001, 3'd1, 8'h10, 8'h04, 6'h20, 1'b0, 8'h0B};
        vecs[11] = '{8'h09, 3'b110, 3'd2, 8'h10, 8'h09, 6'h20, 1'b0, 8'h0B};
        vecs[12] = '{8'h20, 3'b100, 3'd4, 8'h10, 8'h09, 6'h20, 1'b1, 8'h19};
        vecs[13] = '{8'h05, 3'b010, 3'd4, 8'h10, 8'h05, 6'h20, 1'b1, 8'h15};

        reset = 1'b1;
        sw    = 8'h00;
        btn   = 3'b000;
        step(3);
        e = '{8'h00, 3'b000, 3'd0, 8'h00, 8'h00, 6'h00, 1'b0, 8'h00};
        check_all("reset", e);
        reset = 1'b0;
        step(1);

        // Glitch of three samples must not reach the debounced level.
        sw  = 8'h05;
        btn = 3'b001;
        step(3);
        btn = 3'b000;
        step(12);
        check("glitch.a", 32'(alu_a), 32'h00);
        check("glitch.state", 32'(state), 32'd0);

        // Exact latch timing: A visible 7 edges after the first high sample.
        sw  = 8'h05;
        btn = 3'b001;
        step(7);
        check("timed_a.before", 32'(alu_a), 32'h00);
        step(1);
        check("timed_a.after", 32'(alu_a), 32'h05);
        check("timed_a.state", 32'(state), 32'd1);
        step(2);
        btn = 3'b000;
        step(12);

        sw  = 8'h03;
        btn = 3'b010;
        step(7);
        check("timed_b.before", 32'(alu_b), 32'h00);
        step(1);
        check("timed_b.after", 32'(alu_b), 32'h03);
        check("timed_b.state", 32'(state), 32'd2);
        step(2);
        btn = 3'b000;
        step(12);

        // Opcode latch then EXEC, then valid two edges after the press pulse.
        sw  = 8'h20;
        btn = 3'b100;
        step(8);
        check("timed_op.op", 32'(alu_op), 32'h20);
        check("timed_op.exec", 32'(state), 32'd3);
        check("timed_op.valid0", 32'(valid), 32'd0);
        step(1);
        check("timed_op.valid1", 32'(valid), 32'd1);
        check("timed_op.led", 32'(led), 32'h08);
        check("timed_op.show", 32'(state), 32'd4);
        step(1);
        btn = 3'b000;
        step(12);

        // SHOW rerun with new opcode: valid drops for exactly one cycle.
        sw  = 8'h22;
        btn = 3'b100;
        step(7);
        check("rerun.hold_valid", 32'(valid), 32'd1);
        check("rerun.hold_led", 32'(led), 32'h08);
        step(1);
        check("rerun.drop_valid", 32'(valid), 32'd0);
        check("rerun.exec", 32'(state), 32'd3);
        step(1);
        check("rerun.valid", 32'(valid), 32'd1);
        check("rerun.led", 32'(led), 32'h02);
        check("rerun.show", 32'(state), 32'd4);
        step(1);
        btn = 3'b000;
        step(12);

        press_btn(8'h05, 3'b001);
        check("restart.valid", 32'(valid), 32'd0);
        check("restart.state", 32'(state), 32'd1);

        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);

        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(vecs[i]);
            press_btn(vecs[i].sw, vecs[i].btn);
            e = exp_q.pop_front();
            check_all($sformatf("vec%0d", i), e);
        end

        // Reset mid-sequence with btn2 held through and after reset.
        press_btn(8'h01, 3'b001);
        press_btn(8'h02, 3'b010);
        check("midrst.pre_state", 32'(state), 32'd2);
        sw  = 8'h20;
        btn = 3'b100;
        step(3);
        reset = 1'b1;
        step(1);
        e = '{8'h00, 3'b000, 3'd0, 8'h00, 8'h00, 6'h00, 1'b0, 8'h00};
        check_all("midrst", e);
        reset = 1'b0;
        step(12);
        check("midrst.ignored_state", 32'(state), 32'd0);
        check("midrst.ignored_op", 32'(alu_op), 32'h00);
        btn = 3'b000;
        step(12);
        check("midrst.final_state", 32'(state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_btn_sequencer.md
# alu_btn_sequencer

Operand/opcode sequencer for the board-level ALU demo. It takes raw push-buttons and slide switches and debounces each button. A state machine then walks through loading operand A, operand B and the opcode. The ALU instance sits outside this block: the sequencer drives its A, B and opcode inputs and registers its combinational result onto the LEDs with a valid flag.

## Interface
- NB_SW, 8, switch width; must be ≥ max(NB_DATA, NB_OP)
- NB_DATA, 8, operand/result width
- NB_OP, 6, ALU opcode width
- NB_LEDS, 8, LED width
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a level change (≥1)
- i_clk  in  1  single clock, rising-edge
- i_reset  in  1  synchronous, active-high reset
- i_sw  in  NB_SW  slide switches; sampled directly, not synchronised; must be stable around a press
- i_btn  in  3  raw buttons: [0] load A, [1] load B, [2] load opcode
- i_alu_result  in  NB_DATA  combinational result from the external ALU
- o_alu_data_A  out  NB_DATA  registered operand A
- o_alu_data_B  out  NB_DATA  registered operand B
- o_alu_op  out  NB_OP  registered opcode
- o_led  out  NB_LEDS  registered result: low NB_LEDS bits, zero-extended if NB_DATA < NB_LEDS
- o_valid  out  1  o_led holds a result for the current A/B/op
- o_state  out  3  current FSM state encoding

## Operation
- **Per-button front end.**
  - 2-FF synchroniser, then a debounce counter, then a rising-edge detector.
  - The counter increments while the synchronised sample differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - Press = one-cycle pulse on a 0→1 debounced transition. Release produces no pulse.
- **States:** LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4. Codes 5–7 are illegal and go to LOAD_A with o_valid=0.
- **LOAD_A:** press[0] latches A = i_sw[NB_DATA-1:0] and moves to LOAD_B. press[1] and press[2] are ignored.
- **LOAD_B:** press[1] latches B and moves to LOAD_OP. Other presses are ignored.
- **LOAD_OP:** press[2] latches op = i_sw[NB_OP-1:0] and moves to EXEC. Other presses are ignored.
- **EXEC:** lasts exactly one cycle.
  - o_led is loaded from i_alu_result and o_valid is set to 1.
  - Moves to SHOW.
  - Presses arriving in EXEC are dropped.
- **SHOW:** holds o_led and o_valid.
  - press[0]: latch A, clear o_valid, move to LOAD_B (restart the sequence).
  - press[1]: latch B, clear o_valid, move to EXEC (rerun with the new B).
  - press[2]: latch op, clear o_valid, move to EXEC (rerun with the new op).
- **Simultaneous presses:** priority is press[0] > press[1] > press[2]. Only the highest-priority press that is legal in the current state acts; the rest are dropped.
- o_valid is 0 in every state other than SHOW.
- **Reset (any cycle, including mid-sequence):**
  - State goes to LOAD_A.
  - A, B, op, o_led, o_valid, synchronisers, debounced levels and counters all go to 0.
  - A button held through reset produces a press after release of reset once the debounce completes.

## Timing
- Edge k is the first rising edge that samples i_btn[n] high, with the button held high afterwards. Press[n] is high for exactly the cycle starting at edge k+2+DEBOUNCE_CYCLES.
- Latched register and state update is visible after edge k+3+DEBOUNCE_CYCLES.
- A high glitch lasting fewer than DEBOUNCE_CYCLES synchronised samples produces no press and leaves the debounced level unchanged.
- **EXEC capture:** EXEC is entered one edge after the opcode latch. o_led and o_valid update at the edge that exits EXEC, so i_alu_result must settle within one cycle of operand/opcode registration.
- **Latency:** LOAD_OP press pulse to o_valid=1 is 2 clock edges. A SHOW rerun (press[1] or press[2]) also takes 2 edges.
- All outputs are registered; no combinational path exists from i_btn, i_sw or i_alu_result to any output.

## Test plan
- **Reset then full sequence** (DEBOUNCE_CYCLES=4, a stub ALU returning A+B for op=6'h20):
  - Stimulus: sw=8'h05 + btn0 held 10 cycles; then sw=8'h03 + btn1; then sw=8'h20 + btn2.
  - Response: A=05 after 7 edges; B=03; op=20; o_valid=1 and o_led=08, 2 edges after the op press pulse; o_state=4.
- **Glitch rejection:** btn0 high for 3 cycles in LOAD_A → no press, A stays 00, o_state stays 0.
- **Order enforcement:** in LOAD_A, press btn1 then btn2 → A/B/op unchanged, state stays LOAD_A.
- **SHOW rerun:**
  - From SHOW with result 08, set sw=8'h22 (ALU stub op=22 gives A−B) and press btn2.
  - Response: o_valid drops to 0 for one cycle, then o_led=02 and o_valid=1.
  - From SHOW, press btn0 → o_valid=0, o_state=1.
- **Simultaneous presses:** btn0 and btn1 rise on the same edge while in SHOW → only A latches, B is unchanged, next state LOAD_B.
- **Reset mid-operation:** assert i_reset during LOAD_OP with btn2 held → all outputs 0 and o_state=0 on the next edge. After release, the held btn2 produces a press 6 edges later that is ignored in LOAD_A.
